mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Three-way arbiter that shares the single data port of the memory controller between the CPU memory stage, the image processor and the SPART read path. It holds one transaction in flight at a time and latches the winner's address, data and direction onto the memory port until the port acknowledges. It then returns read data and a one-cycle valid strobe to the winner. Priority is fixed, CPU > IMG > SPART, with a starvation counter that promotes SPART after repeated losses.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 8, lost arbitrations before SPART is promoted to top priority (≥1)

- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset: one clock; reset is asynchronous and active-high
- cpu_req  in  1  CPU request, level, held until cpu_vld
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_vld  out  1  one-cycle completion strobe to CPU
- img_req, img_we, img_addr, img_wdata  in  1/1/ADDR_W/DATA_W  image processor request, same rules as CPU
- img_vld  out  1  completion strobe to image processor
- spart_req  in  1  SPART read request (read-only)
- spart_addr  in  ADDR_W  SPART address
- spart_vld  out  1  completion strobe to SPART
- rd_data  out  DATA_W  shared read-data register, qualified by *_vld
- mem_req  out  1  memory port request
- mem_we  out  1  memory port direction
- mem_addr  out  ADDR_W  memory port address
- mem_wdata  out  DATA_W  memory port write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, one cycle
- busy  out  1  high while not in IDLE

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if any req is high, select the winner, latch its we/addr/wdata (we forced to 0 for SPART) and its grant ID, and go to ISSUE. If no req is high, stay in IDLE.
- Winner selection: if spart_req and starve_cnt == STARVE_LIMIT, SPART wins. Otherwise the first requester in the order CPU, IMG, SPART wins.
- ISSUE: mem_req = 1, with mem_we/addr/wdata driven from the latched registers and held constant. On mem_ack, capture mem_rdata into rd_data (reads only; writes leave rd_data unchanged) and go to RESP.
- RESP: assert the grantee's *_vld for exactly one cycle, then return to IDLE.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - updated only at IDLE decisions;
  - +1 (saturating at STARVE_LIMIT) when spart_req is high and SPART loses;
  - cleared when SPART wins or spart_req is low at a decision.
- Requester rule: drop req in the cycle after its vld. A req still high in the IDLE cycle after RESP is a new request.
- Inputs are sampled only in IDLE. Changes to a requester's fields after its grant have no effect.
- Reset: state = IDLE, grant cleared, starve_cnt = 0. All outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, rd_data, all *_vld, busy. An in-flight transaction is abandoned and no vld is issued for it. The memory side must be reset by the same rst.
- mem_ack outside ISSUE is ignored.

## Timing
- Req first high in IDLE at cycle 0 → mem_req high from cycle 1.
- mem_ack in cycle k (k ≥ 1; same-cycle ack allowed) → *_vld high in cycle k+1 → IDLE in cycle k+2.
- Minimum occupancy is 3 cycles per transaction. Minimum request-to-vld latency is 2 cycles.
- busy is high from cycle 1 through the RESP cycle.
- rd_data is registered and stable from the vld cycle until the next read ack.

## Test plan
- Reset: hold rst high with random inputs → every output 0. Deassert rst with no req → IDLE, mem_req stays 0.
- CPU read: cpu_req at cycle 0, addr 0x40; memory acks at cycle 3 with 0x12345678 → mem_req high cycles 1–3, mem_addr 0x40, mem_we 0; cpu_vld high only in cycle 4, rd_data 0x12345678.
- IMG write: img_we=1, addr 0x100, wdata 0xDEADBEEF; img_addr changed at cycle 2; ack at cycle 4 → mem_we 1 and mem_addr 0x100 held through cycle 4; img_vld in cycle 5; rd_data unchanged.
- Simultaneous requests: all three reqs high, each dropped after its vld, ack at cycle 1 every time → grant order CPU, IMG, SPART; each vld fires exactly once.
- Starvation with STARVE_LIMIT=2: CPU and IMG re-request continuously, SPART req held → SPART wins the 3rd decision; starve_cnt returns to 0; then CPU wins the next decision.
- Reset mid-operation: rst at cycle 2 of a CPU read → mem_req drops immediately; no cpu_vld. After release a new cpu_req completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - three-way fixed-priority memory port arbiter (CPU > IMG > SPART) with SPART starvation promotion
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_vld,
    input  logic              img_req,
    input  logic              img_we,
    input  logic [ADDR_W-1:0] img_addr,
    input  logic [DATA_W-1:0] img_wdata,
    output logic              img_vld,
    input  logic              spart_req,
    input  logic [ADDR_W-1:0] spart_addr,
    output logic              spart_vld,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;
    typedef enum logic [1:0] {G_NONE, G_CPU, G_IMG, G_SPART} gnt_t;

    state_t            state_q, state_d;
    gnt_t              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [SC_W-1:0]   starve_q, starve_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            gnt_q     <= G_NONE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            starve_q  <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
            starve_q  <= starve_d;
        end
    end

    always_comb begin
        gnt_t win;
        win       = G_NONE;
        state_d   = state_q;
        gnt_d     = gnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        starve_d  = starve_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req || img_req || spart_req) begin
                    // A starved SPART overrides the fixed order for one decision
                    if (spart_req && starve_q == SC_MAX) win = G_SPART;
                    else if (cpu_req)                    win = G_CPU;
                    else if (img_req)                    win = G_IMG;
                    else                                 win = G_SPART;
                    state_d = S_ISSUE;
                    gnt_d   = win;
                    case (win)
                        G_CPU: begin
                            we_d    = cpu_we;
                            addr_d  = cpu_addr;
                            wdata_d = cpu_wdata;
                        end
                        G_IMG: begin
                            we_d    = img_we;
                            addr_d  = img_addr;
                            wdata_d = img_wdata;
                        end
                        default: begin
                            we_d    = 1'b0;
                            addr_d  = spart_addr;
                            wdata_d = '0;
                        end
                    endcase
                    if (!spart_req || win == G_SPART) starve_d = '0;
                    else if (starve_q != SC_MAX)      starve_d = starve_q + SC_W'(1);
                end
            end
            S_ISSUE: begin
                if (mem_ack) begin
                    if (!we_q) rd_data_d = mem_rdata;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_req   = (state_q == S_ISSUE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rd_data   = rd_data_q;
    assign busy      = (state_q != S_IDLE);
    assign cpu_vld   = (state_q == S_RESP) && (gnt_q == G_CPU);
    assign img_vld   = (state_q == S_RESP) && (gnt_q == G_IMG);
    assign spart_vld = (state_q == S_RESP) && (gnt_q == G_SPART);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int AW = 32, DW = 32, LIMIT = 2;

    logic          clk = 1'b0, rst = 1'b1;
    logic          cpu_req = 0, cpu_we = 0, img_req = 0, img_we = 0, spart_req = 0, mem_ack = 0;
    logic [AW-1:0] cpu_addr = 0, img_addr = 0, spart_addr = 0;
    logic [DW-1:0] cpu_wdata = 0, img_wdata = 0, mem_rdata = 0;
    logic          cpu_vld, img_vld, spart_vld, mem_req, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, rd_data;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_vld(cpu_vld),
        .img_req(img_req), .img_we(img_we), .img_addr(img_addr), .img_wdata(img_wdata), .img_vld(img_vld),
        .spart_req(spart_req), .spart_addr(spart_addr), .spart_vld(spart_vld),
        .rd_data(rd_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    // Requester model: index 0 = CPU, 1 = IMG, 2 = SPART
    bit          pend [3];
    logic        we_m [3];
    logic [31:0] addr_m [3];
    logic [31:0] wdata_m [3];
    int          lost = 0, last_w = -1;
    logic [31:0] rd_exp = 0;

    typedef struct {
        logic [2:0] req;
        int         win;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        cpu_req   = pend[0]; cpu_we = we_m[0]; cpu_addr = addr_m[0]; cpu_wdata = wdata_m[0];
        img_req   = pend[1]; img_we = we_m[1]; img_addr = addr_m[1]; img_wdata = wdata_m[1];
        spart_req = pend[2]; spart_addr = addr_m[2];
    endtask

    task automatic new_req(input int i);
        pend[i]    = 1'b1;
        we_m[i]    = (i != 2) && ($urandom_range(0, 1) == 1);
        addr_m[i]  = $urandom;
        wdata_m[i] = $urandom;
    endtask

    function automatic int predict();
        if (pend[2] && lost == LIMIT) return 2;
        for (int i = 0; i < 3; i++) if (pend[i]) return i;
        return -1;
    endfunction

    task automatic chk_vld(input string name, input int w);
        logic [2:0] e;
        e = (w >= 0) ? (3'b100 >> w) : 3'b000;
        chk(name, 64'({cpu_vld, img_vld, spart_vld}), 64'(e));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, 64'({mem_req, mem_we, cpu_vld, img_vld, spart_vld, busy}), 64'(0));
        chk({tag, "_addr"}, 64'(mem_addr), 64'(0));
        chk({tag, "_wdata"}, 64'(mem_wdata), 64'(0));
        chk({tag, "_rdata"}, 64'(rd_data), 64'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {cpu_req, img_req, spart_req, cpu_we, img_we, mem_ack} = 6'($urandom);
        cpu_addr = $urandom; img_addr = $urandom; spart_addr = $urandom; mem_rdata = $urandom;
        #1 chk_zero("rst_async");
        step(); chk_zero("rst_held");
        for (int i = 0; i < 3; i++) begin pend[i] = 0; we_m[i] = 0; addr_m[i] = 0; wdata_m[i] = 0; end
        drive(); mem_ack = 0;
        rst = 1'b0; lost = 0; rd_exp = 0; last_w = -1;
        step();
        chk("post_rst_idle", 64'({mem_req, busy}), 64'(0));
    endtask

    // One full transaction starting in an IDLE cycle; exp_w < 0 uses the reference model
    task automatic txn(input int exp_w, input int dly, input logic [31:0] rdat);
        int w; logic ew; logic [31:0] ea, ed;
        w = (exp_w >= 0) ? exp_w : predict();
        if (pend[2]) lost = (w == 2) ? 0 : ((lost < LIMIT) ? lost + 1 : LIMIT);
        else         lost = 0;
        ew = we_m[w]; ea = addr_m[w]; ed = wdata_m[w];
        drive(); step();
        chk("issue_req", 64'(mem_req), 64'(1));
        chk("issue_we", 64'(mem_we), 64'(ew));
        chk("issue_addr", 64'(mem_addr), 64'(ea));
        if (ew) chk("issue_wdata", 64'(mem_wdata), 64'(ed));
        chk("issue_busy", 64'(busy), 64'(1));
        if (w != 2) we_m[w] = ~we_m[w];
        addr_m[w] = $urandom; wdata_m[w] = $urandom;
        drive();
        for (int k = 0; k < dly; k++) begin
            step();
            chk("hold_req", 64'(mem_req), 64'(1));
            chk("hold_addr", 64'({mem_we, mem_addr}), 64'({ew, ea}));
            chk_vld("hold_vld", -1);
        end
        mem_ack = 1'b1; mem_rdata = rdat;
        step();
        mem_ack = 1'b0; mem_rdata = $urandom;
        if (!ew) rd_exp = rdat;
        chk_vld("resp_vld", w);
        chk("resp_rdata", 64'(rd_data), 64'(rd_exp));
        chk("resp_memreq", 64'(mem_req), 64'(0));
        pend[w] = 0; drive(); last_w = w;
        step();
        chk_vld("idle_vld", -1);
        chk("idle_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        tbl[0] = '{3'b001, 0}; tbl[1] = '{3'b010, 1}; tbl[2] = '{3'b100, 2};
        tbl[3] = '{3'b011, 0}; tbl[4] = '{3'b110, 1}; tbl[5] = '{3'b101, 0};
        tbl[6] = '{3'b111, 0};

        do_reset();
        repeat (2) begin step(); chk("idle_noreq", 64'({mem_req, busy}), 64'(0)); end

        // CPU read, ack in cycle 3
        pend[0] = 1; we_m[0] = 0; addr_m[0] = 32'h40; wdata_m[0] = 0;
        txn(0, 2, 32'h12345678);
        // IMG write, ack in cycle 4; rd_data must keep the previous read
        pend[1] = 1; we_m[1] = 1; addr_m[1] = 32'h100; wdata_m[1] = 32'hDEADBEEF;
        txn(1, 3, 32'hCAFEF00D);

        foreach (tbl[t]) begin
            do_reset();
            for (int i = 0; i < 3; i++) if (tbl[t].req[i]) new_req(i);
            txn(tbl[t].win, $urandom_range(0, 2), $urandom);
        end

        // All three requesting, immediate acks
        do_reset();
        for (int i = 0; i < 3; i++) new_req(i);
        txn(0, 0, $urandom); txn(1, 0, $urandom); txn(2, 0, $urandom);

        // Starvation: SPART promoted on the third decision
        do_reset();
        for (int i = 0; i < 3; i++) new_req(i);
        txn(0, 0, $urandom);
        txn(1, 0, $urandom);
        new_req(0); txn(2, 1, $urandom);
        new_req(1); txn(0, 0, $urandom);

        // Reset in cycle 2 of a CPU read
        do_reset();
        new_req(0); we_m[0] = 0; drive();
        step(); step();
        #2 rst = 1'b1;
        #1 chk("midrst_memreq", 64'({mem_req, busy}), 64'(0));
        step();
        pend[0] = 0; drive(); rst = 1'b0;
        repeat (3) begin step(); chk_vld("midrst_novld", -1); end
        lost = 0; rd_exp = 0; last_w = -1;
        new_req(0); txn(0, 1, $urandom);

        // Randomized traffic against the reference model
        do_reset();
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 3; i++)
                if (!pend[i] && i != last_w && $urandom_range(0, 2) != 0) new_req(i);
            if (!(pend[0] || pend[1] || pend[2])) begin
                drive();
                mem_ack = ($urandom_range(0, 1) == 1);
                step();
                mem_ack = 1'b0;
                chk("rand_idle", 64'({mem_req, busy}), 64'(0));
                last_w = -1;
            end else begin
                txn(-1, $urandom_range(0, 3), $urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
